// File: rtl/alu_cmd_seq_pkg.sv
// Shared widths, FSM state encoding and ALU opcode/segment constants for alu_cmd_seq.
package alu_cmd_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_NOT = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_RSV = 3'b110;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/alu_cmd_seq_btn_debounce.sv
// Enter-button conditioning: 2-flop synchronizer, optional debouncer, rising-edge pulse.
// Debouncer is built only when ALU_CMD_SEQ_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic w_level;
  logic r_level_d;
  logic r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef ALU_CMD_SEQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_level = r_level;
`else
  logic w_unused_db;
  assign w_unused_db = ^DB_CYCLES;
  assign w_level     = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_press   <= w_level & ~r_level_d;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/alu_cmd_seq.sv
// Switch/button entry sequencer for the 4-bit ALU: collects A, B, op, then latches the result.
// Button debouncing is enabled by defining ALU_CMD_SEQ_DEBOUNCE_EN.
module alu_cmd_seq
  import alu_cmd_seq_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn,
  input  logic              clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [SEG_W-1:0]  alu_seg,
  output logic [SEG_W-1:0]  disp_seg,
  output logic              res_valid,
  output logic [ST_W-1:0]   state_o
);

  logic              w_press;
  state_e            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [SEG_W-1:0]  r_disp;
  logic              r_valid;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .press (w_press)
  );

  // clr takes priority over any press; disp_seg survives clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_disp  <= SEG_BLANK;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_A: if (w_press) begin
          r_a     <= sw;
          r_state <= S_B;
        end
        S_B: if (w_press) begin
          r_b     <= sw;
          r_state <= S_OP;
        end
        S_OP: if (w_press) begin
          r_op    <= sw[OP_W-1:0];
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_disp  <= alu_seg;
          r_valid <= 1'b1;
          r_state <= S_SHOW;
        end
        S_SHOW: if (w_press) begin
          r_valid <= 1'b0;
          r_state <= S_A;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign disp_seg  = r_disp;
  assign res_valid = r_valid;
  assign state_o   = ST_W'(r_state);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq with a small combinational ALU stub.
module tb_alu_cmd_seq;

`ifdef ALU_CMD_SEQ_DEBOUNCE_EN
  localparam int DBL = 16;
`else
  localparam int DBL = 0;
`endif
  localparam logic [6:0] SEG8  = 7'h00;
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic       clr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [6:0] alu_seg;
  logic [6:0] disp_seg;
  logic       res_valid;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_cmd_seq #(.DB_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn       (btn),
    .clr       (clr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_seg   (alu_seg),
    .disp_seg  (disp_seg),
    .res_valid (res_valid),
    .state_o   (state_o)
  );

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  // ALU stub: combinational from the sequencer's operand outputs.
  always_comb begin
    logic [3:0] r;
    case (alu_op)
      3'b000:  r = alu_a + alu_b;
      3'b001:  r = alu_a - alu_b;
      3'b010:  r = ~alu_a;
      3'b011:  r = alu_a & alu_b;
      3'b100:  r = alu_a | alu_b;
      3'b101:  r = alu_a ^ alu_b;
      3'b111:  r = {3'b000, alu_a == alu_b};
      default: r = 4'h0;
    endcase
    alu_seg = seg7(r);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold btn long enough for the press to take effect; returns just after the FSM update edge.
  task automatic press_hold(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    tick(DBL + 4);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    tick(DBL + 4);
  endtask

  initial begin
    rst_n = 1'b0; sw = 4'h0; btn = 1'b0; clr = 1'b0;
    tick(3);
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_a", 8'(alu_a), 8'd0);
    chk("rst_b", 8'(alu_b), 8'd0);
    chk("rst_op", 8'(alu_op), 8'd0);
    chk("rst_disp", 8'(disp_seg), 8'(BLANK));
    chk("rst_valid", 8'(res_valid), 8'd0);
    rst_n = 1'b1;
    tick(2);

    // Latency: btn first sampled at edge N; press in cycle after N+2+DBL; state moves at N+3+DBL.
    sw  = 4'h3;
    btn = 1'b1;
`ifndef ALU_CMD_SEQ_DEBOUNCE_EN
    tick(1);
    btn = 1'b0;
    tick(DBL + 2);
`else
    tick(DBL + 3);
`endif
    chk("lat_before", 8'(state_o), 8'd0);
    tick(1);
    chk("lat_after", 8'(state_o), 8'd1);
    chk("a_load", 8'(alu_a), 8'd3);
    release_btn();
    tick(DBL + 4);
    chk("no_release_press", 8'(state_o), 8'd1);

    press_hold(4'h5);
    chk("b_state", 8'(state_o), 8'd2);
    chk("b_load", 8'(alu_b), 8'd5);
    release_btn();

    // sw[3] set: opcode must still be ADD.
    press_hold(4'h8);
    chk("op_load", 8'(alu_op), 8'd0);
    chk("calc_state", 8'(state_o), 8'd3);
    chk("calc_valid", 8'(res_valid), 8'd0);
    chk("calc_disp", 8'(disp_seg), 8'(BLANK));
    tick(1);
    chk("show_state", 8'(state_o), 8'd4);
    chk("show_disp", 8'(disp_seg), 8'(SEG8));
    chk("show_valid", 8'(res_valid), 8'd1);
    release_btn();

`ifdef ALU_CMD_SEQ_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      tick(3);
    end
    btn = 1'b0;
    tick(DBL + 8);
    chk("bounce_state", 8'(state_o), 8'd4);
    chk("bounce_valid", 8'(res_valid), 8'd1);
`endif

    press_hold(4'hF);
    chk("show_exit_state", 8'(state_o), 8'd0);
    chk("show_exit_valid", 8'(res_valid), 8'd0);
    chk("show_exit_disp", 8'(disp_seg), 8'(SEG8));
    chk("keep_a", 8'(alu_a), 8'd3);
    chk("keep_b", 8'(alu_b), 8'd5);
    chk("keep_op", 8'(alu_op), 8'd0);
    release_btn();

    press_hold(4'h9);
    chk("a2_load", 8'(alu_a), 8'd9);
    chk("a2_state", 8'(state_o), 8'd1);
    release_btn();

    // clr asserted in the press cycle while in S_B.
    sw  = 4'h6;
    btn = 1'b1;
    tick(DBL + 3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_state", 8'(state_o), 8'd0);
    chk("clr_a", 8'(alu_a), 8'd0);
    chk("clr_b", 8'(alu_b), 8'd0);
    chk("clr_valid", 8'(res_valid), 8'd0);
    chk("clr_disp", 8'(disp_seg), 8'(SEG8));
    release_btn();
    chk("clr_press_dropped", 8'(state_o), 8'd0);

    press_hold(4'h7);
    chk("after_clr_a", 8'(alu_a), 8'd7);
    chk("after_clr_state", 8'(state_o), 8'd1);
    release_btn();

    // Asynchronous reset mid-sequence.
    rst_n = 1'b0;
    #2;
    chk("arst_state", 8'(state_o), 8'd0);
    chk("arst_a", 8'(alu_a), 8'd0);
    chk("arst_disp", 8'(disp_seg), 8'(BLANK));
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Operand/opcode entry sequencer that drives the 4-bit ALU from board switches and one enter button. It collects A, B and op in turn, applies them to the ALU's operand inputs and latches the ALU's 7-segment result for display. It sits between the board I/O (switches, button, display) and the combinational ALU, so the ALU can be exercised on hardware without wiring all 11 operand/op bits to switches.

## Interface
- DB_CYCLES, 16: consecutive stable synchronized cycles required before the debounced button changes level (≥2).
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  data switches, sampled raw in the accepted-press cycle
- btn  in  1  enter button, asynchronous, active-high
- clr  in  1  synchronous abort, active-high, already synchronous to clk
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_seg  in  7  ALU 7-segment output, combinational from alu_a/alu_b/alu_op
- disp_seg  out  7  latched result segments, active-low
- res_valid  out  1  disp_seg holds a result for the current operands
- state_o  out  3  current FSM state for LEDs

## Operation
- Reset/clock naming: one clock clk; reset rst_n is asynchronous, active-low.
- Button path: 2-flop synchronizer → debouncer → rising-edge detector. Output is a one-cycle press pulse.
- Debouncer: counter restarts whenever the synchronized level equals the debounced level. When the levels differ for DB_CYCLES consecutive cycles, the debounced level flips.
- FSM states:
  - S_A = 0. On press: alu_a ← sw, then S_B.
  - S_B = 1. On press: alu_b ← sw, then S_OP.
  - S_OP = 2. On press: alu_op ← sw[2:0] (sw[3] ignored), then S_CALC.
  - S_CALC = 3. Unconditional, one cycle: disp_seg ← alu_seg, res_valid ← 1, then S_SHOW.
  - S_SHOW = 4. On press: res_valid ← 0, then S_A. disp_seg keeps its old value.
- Entering S_A from S_SHOW: alu_a, alu_b and alu_op are kept until they are overwritten.
- clr: from any state goes to S_A, zeroes alu_a, alu_b and alu_op, and clears res_valid. disp_seg is kept.
- Simultaneous clr and press: clr wins and the press is discarded.
- Press in S_CALC: ignored. It cannot occur in practice, because the debounced edge rate is well below one per cycle.
- state_o values 5–7 are unreachable. If the FSM is ever in one of them, it returns to S_A.

## Timing
- Reset values:
  - state S_A
  - alu_a, alu_b, alu_op = 0
  - disp_seg = 7'h7F (blank)
  - res_valid = 0
  - synchronizer, debouncer level, counter and edge flops = 0
- Debounced press latency: btn first sampled high at edge N and held → press pulse in the cycle after edge N+2+DB_CYCLES.
- Register update: operand/opcode registers update on the edge that ends the press cycle.
- Result latch: disp_seg is captured exactly one cycle after alu_op updates. The ALU is combinational; no further wait is needed.
- Reset asserted mid-sequence: all registers return to their reset values immediately, asynchronously.

## Configuration
- ALU_CMD_SEQ_DEBOUNCE_EN
  - Defined: debouncer present, latency as above. DB_CYCLES is honoured.
  - Undefined: the debounced level is the synchronizer output directly. The press pulse arrives in the cycle after edge N+2. DB_CYCLES is ignored and a single-cycle glitch counts as a press.

## Structure
- Package alu_cmd_seq_pkg:
  - state enum (S_A..S_SHOW, 3 bits)
  - opcode constants matching the ALU: ADD=000, SUB=001, NOT=010, AND=011, OR=100, XOR=101, RSV=110, EQ=111
  - SEG_BLANK = 7'h7F
- One sub-module, btn_debounce: synchronizer, debouncer (macro-controlled) and edge detector. Parameter DB_CYCLES; outputs the press pulse.

## Test plan
- Reset with rst_n low for 3 cycles → state_o=0, alu_a/alu_b/alu_op=0, disp_seg=7'h7F, res_valid=0.
- Clean presses with sw=3, then 5, then 0 (ALU stub returns seg(8)) → alu_a=3, alu_b=5, alu_op=0; disp_seg=seg(8) and res_valid=1 one cycle after alu_op updates; state_o=4.
- DB_CYCLES=16, btn toggling every 3 cycles for 30 cycles and then low → no press pulse; state_o unchanged.
- In S_B, clr and a press in the same cycle → state_o=0, alu_a=0, res_valid=0, disp_seg unchanged.
- Press in S_SHOW after a result of seg(8) → state_o=0, res_valid=0, disp_seg still seg(8), alu_a/alu_b/alu_op retained.
- Macro undefined, btn high for exactly 1 cycle at edge N → press pulse in the cycle after edge N+2; state_o advances 0→1.
